ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Parametrised write/read-back sequencer for a single-port synchronous RAM.
- Fills every location from 0 to DEPTH-1 with a selectable data pattern, then reads every location back.
- Compares each read word against the expected pattern and reports error count, first failing address and pass/fail.
- Sits between the top-level start control and the RAM IP; the RAM drives rd_data back into this block.

Parameters:
- AW, 8: address width.
- DW, 8: data width.
- DEPTH, 256: number of locations tested; 2 <= DEPTH <= 2^AW.
- RD_LAT, 1: RAM read latency in cycles, 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  begin a test; sampled in IDLE and DONE only.
- mode  in  2  pattern select; latched at start.
- seed  in  DW  pattern seed; latched at start.
- loop  in  1  1 = restart automatically after each pass; sampled at the end of READ-drain.
- addr_out  out  AW  RAM address.
- data_out  out  DW  RAM write data.
- wren  out  1  RAM write enable; 1 = write.
- rden  out  1  RAM read enable.
- rd_data  in  DW  RAM read data, valid RD_LAT cycles after rden/addr_out.
- busy  out  1  test in progress.
- done  out  1  level, held while in DONE.
- pass  out  1  valid when done=1; 1 = err_cnt is 0.
- err_cnt  out  16  mismatch count; saturates at 16'hFFFF.
- first_err_addr  out  AW  address of the first mismatch since start; 0 if none.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, and every output is 0.
- Output timing: all outputs are registered and change only on the rising edge of clk.
- Pattern p(a), with a zero-extended or truncated to DW and all arithmetic modulo 2^DW:
  - mode0: a + seed
  - mode1: ~(a + seed)
  - mode2: a[0] ? ~seed : seed (checkerboard)
  - mode3: seed (constant)
- State IDLE: busy=0, wren=0, rden=0.
  - start=1 latches mode and seed, clears err_cnt, first_err_addr and pass, then goes to WRITE with address 0.
- State WRITE: one write per cycle: wren=1, rden=0, addr_out=a, data_out=p(a).
  - After a=DEPTH-1, go to READ with a=0 on the next cycle, with no idle gap.
- State READ: one read per cycle: rden=1, wren=0, data_out=0, addr_out=a.
  - The expected value and address travel through an RD_LAT-deep valid/address shift register.
  - rd_data is compared at the matching edge.
  - On mismatch: err_cnt increments (saturating); if err_cnt was 0, first_err_addr captures the address.
  - After a=DEPTH-1, go to DRAIN.
- State DRAIN: rden=0; wait RD_LAT cycles until the shift register is empty, then go to DONE.
- State DONE: done=1, busy=0, pass=(err_cnt==0).
  - If loop=1, go to WRITE at address 0 the next cycle. err_cnt and first_err_addr are kept; pass is recomputed at each DONE.
  - Otherwise stay in DONE until start=1, which is handled as in IDLE.
- Latency: done rises 2*DEPTH+RD_LAT+1 edges after the edge that sampled start.
- start while busy: ignored. mode and seed changes while busy: ignored.
- Address wrap: the address counter never exceeds DEPTH-1, even when DEPTH < 2^AW.
- rst mid-operation: the next edge forces IDLE, with wren, rden and busy at 0 and counters cleared; in-flight compares are discarded.

Test Plan (defaults unless stated):
1. rst, then start with mode0, seed=0 -> addresses 0..255 written with data 0..255; addresses 0..255 read; done=1 on edge 514 after start; pass=1; err_cnt=0.
2. Same as 1, but the bench RAM flips bit0 on reads of 0x10 and 0x80 -> err_cnt=2, first_err_addr=0x10, pass=0.
3. mode2, seed=8'h55 -> write data alternates 55,AA,55,...; mode1, seed=3 -> address 0 data=FC, address 255 data=FD; both pass=1.
4. rst pulsed while WRITE is at address 0x40; start pulsed again mid-READ -> after rst: wren=0, busy=0, err_cnt=0, state IDLE; the mid-READ start has no effect on addr_out.
5. DEPTH=100, RD_LAT=3 -> write addresses wrap 99->0 into READ; done on edge 204; pass=1.
6. loop=1 with a fault at address 5 -> err_cnt=1, 2, 3 at successive DONEs; drop loop -> stays in DONE with err_cnt=3.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back BIST sequencer for a single-port synchronous RAM
module ram_bist_ctrl #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] seed,
    input  logic          loop,
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] data_out,
    output logic          wren,
    output logic          rden,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_addr
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                   state, state_n;
    logic [1:0]               mode_q, mode_n;
    logic [DW-1:0]            seed_q, seed_n;
    logic [AW-1:0]            addr_n;
    logic                     accept, last, mismatch;
    logic [RD_LAT-1:0]        vld;
    logic [RD_LAT-1:0][AW-1:0] pa;

    function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [DW-1:0] s,
                                              input logic [AW-1:0] a);
        logic [DW-1:0] sum;
        sum = DW'(a) + s;
        return m == 2'd0 ? sum : m == 2'd1 ? ~sum : m == 2'd2 ? (a[0] ? ~s : s) : s;
    endfunction

    // next-state, address sequencing and compare decision
    always_comb begin
        accept   = start && (state == IDLE || (state == DONE && !loop));
        last     = addr_out == AW'(DEPTH - 1);
        mode_n   = accept ? mode : mode_q;
        seed_n   = accept ? seed : seed_q;
        mismatch = vld[RD_LAT-1] && rd_data != pattern(mode_q, seed_q, pa[RD_LAT-1]);
        state_n  = state;
        addr_n   = addr_out;
        case (state)
            IDLE:  state_n = accept ? WRITE : IDLE;
            WRITE: begin
                state_n = last ? READ : WRITE;
                addr_n  = last ? '0 : addr_out + 1'b1;
            end
            READ:  begin
                state_n = last ? DRAIN : READ;
                addr_n  = last ? '0 : addr_out + 1'b1;
            end
            DRAIN: state_n = |vld ? DRAIN : DONE;
            DONE:  state_n = (loop || accept) ? WRITE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // state, registered RAM strobes, status outputs and read-compare pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mode_q         <= '0;
            seed_q         <= '0;
            addr_out       <= '0;
            data_out       <= '0;
            wren           <= 1'b0;
            rden           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            vld            <= '0;
            pa             <= '0;
        end else begin
            state          <= state_n;
            mode_q         <= mode_n;
            seed_q         <= seed_n;
            addr_out       <= addr_n;
            wren           <= state_n == WRITE;
            rden           <= state_n == READ;
            data_out       <= state_n == WRITE ? pattern(mode_n, seed_n, addr_n) : '0;
            busy           <= state_n inside {WRITE, READ, DRAIN};
            done           <= state_n == DONE;
            pass           <= state_n == DONE && err_cnt == '0;
            err_cnt        <= accept ? '0 : (mismatch && err_cnt != 16'hFFFF) ? err_cnt + 1'b1 : err_cnt;
            first_err_addr <= accept ? '0 : (mismatch && err_cnt == '0) ? pa[RD_LAT-1] : first_err_addr;
            vld            <= RD_LAT'({vld, rden});
            pa             <= (RD_LAT * AW)'({pa, addr_out});
        end
    end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: randomized scoreboard bench for ram_bist_ctrl with behavioural RAM models
module tb_ram_bist_ctrl;
    localparam int AW = 8, DW = 8, DEPTH = 256, RD_LAT = 1;
    localparam int LAT = 2 * DEPTH + RD_LAT + 1;

    logic clk = 0, rst = 1, start = 0, loop = 0;
    logic [1:0] mode = 0;
    logic [DW-1:0] seed = 0;
    logic [AW-1:0] addr_out, first_err_addr;
    logic [DW-1:0] data_out, rd_data;
    logic wren, rden, busy, done, pass;
    logic [15:0] err_cnt;

    logic b_rst = 1, b_start = 0;
    logic [1:0] b_mode = 0;
    logic [DW-1:0] b_seed = 0;
    logic [AW-1:0] b_addr, b_first;
    logic [DW-1:0] b_data, b_rd;
    logic b_wren, b_rden, b_busy, b_done, b_pass, b_fin = 0;
    logic [15:0] b_err;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .loop(loop),
        .addr_out(addr_out), .data_out(data_out), .wren(wren), .rden(rden), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr));

    ram_bist_ctrl #(.AW(8), .DW(8), .DEPTH(100), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .mode(b_mode), .seed(b_seed), .loop(1'b0),
        .addr_out(b_addr), .data_out(b_data), .wren(b_wren), .rden(b_rden), .rd_data(b_rd),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err), .first_err_addr(b_first));

    // RAM model A: one-cycle read latency, bit0 flipped on reads of addresses in fault_map
    logic [DW-1:0] mem [2**AW];
    logic [2**AW-1:0] fault_map = '0;
    always @(posedge clk) begin
        if (wren) mem[addr_out] <= data_out;
        rd_data <= mem[addr_out] ^ {{(DW-1){1'b0}}, fault_map[addr_out]};
    end

    // RAM model B: three-cycle read latency
    logic [DW-1:0] b_mem [256];
    logic [DW-1:0] b_q [3];
    always @(posedge clk) begin
        if (b_wren) b_mem[b_addr] <= b_data;
        b_q[0] <= b_mem[b_addr];
        b_q[1] <= b_q[0];
        b_q[2] <= b_q[1];
    end
    assign b_rd = b_q[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [DW-1:0] s, input int a);
        logic [DW-1:0] av;
        av = DW'(a);
        case (m)
            2'd0: return av + s;
            2'd1: return ~(av + s);
            2'd2: return a[0] ? ~s : s;
            default: return s;
        endcase
    endfunction

    typedef struct {
        int lat;
        bit from_done;
        logic [15:0] err;
        logic [AW-1:0] first;
        logic pass;
    } exp_t;
    exp_t sbq[$];
    int start_cyc = 0, last_done_cyc = 0;
    logic [1:0] cur_mode = 0;
    logic [DW-1:0] cur_seed = 0;

    // monitor: pops the scoreboard at each done rise and checks every write/read beat
    initial begin
        exp_t e;
        logic done_q, wren_q, rden_q;
        logic [AW-1:0] wa, ra;
        done_q = 0; wren_q = 0; rden_q = 0; wa = 0; ra = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_q = 0; wren_q = 0; rden_q = 0;
            end else begin
                if (done && !done_q) begin
                    if (sbq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL sb_empty: done rose with no expected result queued (cycle %0d)", cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_latency", cyc - (e.from_done ? last_done_cyc : start_cyc), e.lat);
                        chk("err_cnt", err_cnt, e.err);
                        chk("first_err_addr", first_err_addr, e.first);
                        chk("pass", pass, e.pass);
                    end
                    last_done_cyc = cyc;
                end
                if (wren) begin
                    wa = wren_q ? wa + 1'b1 : '0;
                    chk("wr_addr", addr_out, wa);
                    chk("wr_data", data_out, pat(cur_mode, cur_seed, int'(wa)));
                end
                if (rden) begin
                    ra = rden_q ? ra + 1'b1 : '0;
                    chk("rd_addr", addr_out, ra);
                end
                if (wren || rden) chk("strobe_excl", {wren, rden, busy}, {wren, ~wren, 1'b1});
                done_q = done; wren_q = wren; rden_q = rden;
            end
        end
    end

    task automatic do_start(input logic [1:0] m, input logic [DW-1:0] s);
        @(negedge clk);
        mode = m; seed = s; start = 1; cur_mode = m; cur_seed = s;
        @(negedge clk);
        start = 0; start_cyc = cyc;
        mode = 2'($urandom); seed = DW'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * LAT && !done; i++) @(negedge clk);
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: done stayed 0 (cycle %0d)", cyc);
        end
    endtask

    function automatic exp_t model(input int lat, input bit fd, input int extra);
        exp_t e;
        int n;
        n = 0;
        e.first = '0;
        for (int a = DEPTH - 1; a >= 0; a--) if (fault_map[a]) begin n++; e.first = AW'(a); end
        e.lat = lat; e.from_done = fd;
        e.err = 16'(n * extra);
        e.pass = (n == 0);
        return e;
    endfunction

    task automatic run_test(input logic [1:0] m, input logic [DW-1:0] s);
        sbq.push_back(model(LAT, 0, 1));
        do_start(m, s);
        chk("busy_after_start", busy, 1);
        wait_done();
    endtask

    task automatic rand_faults();
        fault_map = '0;
        repeat ($urandom_range(0, 3)) fault_map[$urandom_range(0, DEPTH - 1)] = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {addr_out, data_out, wren, rden, busy, done, pass, err_cnt, first_err_addr}, 0);
        rst = 0;
        run_test(2'd0, 8'h00);
        fault_map[8'h10] = 1; fault_map[8'h80] = 1;
        run_test(2'd0, 8'h00);
        fault_map = '0;
        run_test(2'd2, 8'h55);
        run_test(2'd1, 8'h03);
        repeat (6) begin
            rand_faults();
            run_test(2'($urandom), DW'($urandom));
        end
        // start pulsed mid-READ must be ignored
        rand_faults();
        sbq.push_back(model(LAT, 0, 1));
        do_start(2'($urandom), DW'($urandom));
        for (int i = 0; i < 2 * LAT && !(rden && addr_out == 8'h30); i++) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("mid_read_start_addr", {rden, wren, addr_out}, {1'b1, 1'b0, 8'h31});
        wait_done();
        // reset in the middle of WRITE
        fault_map = '0;
        do_start(2'd0, 8'h11);
        for (int i = 0; i < 2 * LAT && !(wren && addr_out == 8'h40); i++) @(negedge clk);
        chk("pre_rst_write_addr", addr_out, 8'h40);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_write", {wren, rden, busy, done, addr_out, err_cnt}, 0);
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {busy, wren, done}, 0);
        // auto-restart accumulating errors, then drop loop
        fault_map = '0; fault_map[5] = 1;
        loop = 1;
        sbq.push_back(model(LAT, 0, 1));
        sbq.push_back(model(LAT + 1, 1, 2));
        sbq.push_back(model(LAT + 1, 1, 3));
        do_start(2'($urandom), DW'($urandom));
        wait_done();
        @(negedge clk);
        wait_done();
        @(negedge clk);
        loop = 0;
        wait_done();
        repeat (10) @(negedge clk);
        chk("stay_done", {done, busy, pass, err_cnt}, {1'b1, 1'b0, 1'b0, 16'd3});
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_in_done", {done, err_cnt, first_err_addr, pass}, 0);
        chk("sb_drained", sbq.size(), 0);
        for (int i = 0; i < 5000 && !b_fin; i++) @(negedge clk);
        if (!b_fin) begin
            n_cmp++; n_bad++;
            $display("FAIL b_timeout: second instance did not finish");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // DEPTH=100, RD_LAT=3 instance: address wrap into READ, latency and pass
    initial begin : b_proc
        int wc, rc, sc;
        logic pw;
        logic [7:0] pad;
        logic [1:0] bm;
        wc = 0; rc = 0; pw = 0; pad = 0;
        repeat (3) @(negedge clk);
        b_rst = 0;
        @(negedge clk);
        bm = 2'($urandom);
        b_mode = bm; b_seed = 8'($urandom); b_start = 1;
        @(negedge clk);
        b_start = 0; sc = cyc;
        for (int i = 0; i < 400 && !b_done; i++) begin
            if (b_wren) begin
                chk("b_wr_addr", b_addr, wc);
                chk("b_wr_data", b_data, pat(bm, b_seed, wc));
                wc++;
            end
            if (b_rden) begin
                if (rc == 0) chk("b_wrap", {pw, pad}, {1'b1, 8'd99});
                chk("b_rd_addr", b_addr, rc);
                rc++;
            end
            pw = b_wren; pad = b_addr;
            @(negedge clk);
        end
        chk("b_done", b_done, 1);
        chk("b_latency", cyc - sc, 2 * 100 + 3 + 1);
        chk("b_result", {b_pass, b_err, b_first}, {1'b1, 16'd0, 8'd0});
        chk("b_counts", {wc[15:0], rc[15:0]}, {16'd100, 16'd100});
        b_fin = 1;
    end
endmodule
